psum_add_sched: RTL and testbench
=================================

# psum_add_sched

Round-robin scheduler that shares one WIDTH-bit ripple-carry adder among NREQ requesters (PE partial-sum accumulation ports). It accepts one add request per cycle, adds the operands with an optional per-requester carry-in for multi-word chaining, and returns the result through a single registered, back-pressured response slot tagged with the requester ID. A lock bit keeps the adder dedicated to one requester for the duration of a multi-word sequence.

## Interface
- WIDTH, 16, operand/sum width in bits.
- NREQ, 4, number of requesters (≥2); IDW = clog2(NREQ) derived internally.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- req_op1  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_op2  in  NREQ*WIDTH  operand B, same packing.
- req_chain  in  NREQ  1 = use requester's stored carry as carry-in; 0 = carry-in 0.
- req_lock  in  NREQ  1 = keep adder locked to this requester after this op.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  requester index of response.
- rsp_sum  out  WIDTH  op1 + op2 + cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.

## Operation
- Slot free condition: free = !rsp_valid | rsp_ready.
- Arbitration (state UNLOCKED): if free, grant the first i with req_valid[i] searching ptr, ptr+1, …, NREQ-1, 0, … (wrap). req_ready is at most one-hot; all zero when !free or no valid.
- On transfer from i: ptr <= (i+1) mod NREQ.
- State LOCKED(owner): entered when the accepted op has req_lock=1; only owner may be granted (req_ready[owner] = free); other requests wait regardless of ptr. Leave to UNLOCKED when owner's accepted op has req_lock=0. ptr is not updated while in LOCKED and is set to owner+1 on exit.
- Carry store cy[NREQ]: on transfer from i, cin = req_chain[i] ? cy[i] : 0; cy[i] <= cout. Other cy entries hold.
- Result: {cout,sum} = op1 + op2 + cin computed combinationally and registered into rsp_* on transfer; rsp_valid <= 1.
- Response: if rsp_valid & rsp_ready and no new transfer, rsp_valid <= 0; rsp_sum/rsp_id/rsp_cout hold last value.
- Simultaneous drain and accept in the same cycle: slot overwritten with new result, rsp_valid stays 1.
- req_valid is not required to stay high without grant; dropping it withdraws the request with no side effects.
- Reset mid-operation: pending response is lost, lock released, cy cleared.

## Timing
- Reset values: rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, ptr 0, state UNLOCKED, cy all 0; req_ready forced 0 while rst_n low.
- req_ready combinational from req_valid, rsp_ready, state, ptr (no comb path from operands).
- Latency: accept at edge N → rsp_* valid after edge N, visible in cycle N+1.
- Throughput: one op/cycle while rsp_ready=1; zero accepts while rsp_valid=1 & rsp_ready=0.
- rsp_* stable while rsp_valid=1 & rsp_ready=0.

## Test plan
- Single op: req 0 op1=0x1234, op2=0x0FFF, chain=0 → next cycle rsp_valid=1, id=0, sum=0x2233, cout=0.
- Round-robin: all 4 valid continuously, rsp_ready=1 → grants 0,1,2,3,0,… one per cycle; rsp_id follows same order one cycle later.
- Chaining: req 2 op 0xFFFF+0x0001 chain=0 (sum 0x0000, cout 1), then 0x0000+0x0000 chain=1 → sum 0x0001, cout 0; a chain=1 op on req 3 uses cin=0 (cy[3]=0).
- Lock: req 1 sends lock=1, lock=1, lock=0 while reqs 0,2,3 valid → three consecutive grants to 1, then grant 2 (ptr=2).
- Back-pressure: rsp_ready=0 for 3 cycles with response pending → req_ready all 0, rsp_* stable; rsp_ready=1 → drain and new accept same cycle, rsp_valid stays 1.
- Reset: assert rst_n=0 during LOCKED with rsp_valid=1 → immediately rsp_valid=0, req_ready=0; after release, round-robin restarts at requester 0 with cy cleared.

Source files
------------

// File: rtl/psum_add_sched.sv
// Round-robin scheduler sharing one ripple-carry adder among NREQ partial-sum ports,
// with per-requester carry chaining, a lock for multi-word sequences and one response slot.
module psum_add_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_op1,
    input  logic [NREQ*WIDTH-1:0] req_op2,
    input  logic [NREQ-1:0]       req_chain,
    input  logic [NREQ-1:0]       req_lock,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]    cy_q, cy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;

    logic               free;
    logic [NREQ-1:0]    gnt_oh;
    logic [IDW-1:0]     gnt_idx;
    logic               found;
    int                 idx;
    logic               xfer;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               cin;
    logic [WIDTH:0]     add_res;
    logic [IDW-1:0]     ptr_next;

    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             ci);
        logic             c;
        logic [WIDTH-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    assign free = !rsp_valid_q || rsp_ready;

    // Locked: only the owner is eligible; otherwise search from ptr with wrap.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (state_q == LOCKED) begin
            if (free && req_valid[owner_q]) begin
                gnt_oh[owner_q] = 1'b1;
                gnt_idx         = owner_q;
            end
        end else if (free) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr_q) + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found       = 1'b1;
                    gnt_oh[idx] = 1'b1;
                    gnt_idx     = IDW'(idx);
                end
            end
        end
    end

    assign req_ready = rst_n ? gnt_oh : '0;
    assign xfer      = |gnt_oh;

    assign op_a     = req_op1[gnt_idx*WIDTH +: WIDTH];
    assign op_b     = req_op2[gnt_idx*WIDTH +: WIDTH];
    assign cin      = req_chain[gnt_idx] & cy_q[gnt_idx];
    assign add_res  = ripple_add(op_a, op_b, cin);
    assign ptr_next = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    // While locked the owner is the only grantee, so ptr = owner+1 on exit falls out naturally.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cy_d        = cy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        if (xfer) begin
            ptr_d         = ptr_next;
            cy_d[gnt_idx] = add_res[WIDTH];
            rsp_valid_d   = 1'b1;
            rsp_id_d      = gnt_idx;
            rsp_sum_d     = add_res[WIDTH-1:0];
            rsp_cout_d    = add_res[WIDTH];
            state_d       = req_lock[gnt_idx] ? LOCKED : UNLOCKED;
            owner_d       = gnt_idx;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            owner_q     <= '0;
            ptr_q       <= '0;
            cy_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cy_q        <= cy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_psum_add_sched.sv
// Directed bench for psum_add_sched: reset, single op, round-robin, chaining,
// lock, back-pressure and reset during a locked sequence.
module tb_psum_add_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [3:0]  req_chain;
    logic [3:0]  req_lock;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;

    int n_checks = 0;
    int n_errors = 0;

    psum_add_sched #(.WIDTH(16), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_chain (req_chain),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic l);
        req_op1[i*16 +: 16] = a;
        req_op2[i*16 +: 16] = b;
        req_chain[i]        = c;
        req_lock[i]         = l;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id,
                           input logic [15:0] sum, input logic cout);
        chk_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk_eq({tag, "_id"},    32'(rsp_id),    32'(id));
        chk_eq({tag, "_sum"},   32'(rsp_sum),   32'(sum));
        chk_eq({tag, "_cout"},  32'(rsp_cout),  32'(cout));
    endtask

    int rr_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_op1   = '0;
        req_op2   = '0;
        req_chain = '0;
        req_lock  = '0;

        #3;
        chk_eq("rst_ready", 32'(req_ready), 32'h0);
        chk_eq("rst_valid", 32'(rsp_valid), 32'h0);
        chk_eq("rst_sum",   32'(rsp_sum),   32'h0);
        chk_eq("rst_cout",  32'(rsp_cout),  32'h0);
        chk_eq("rst_id",    32'(rsp_id),    32'h0);
        #10;
        rst_n     = 1'b1;
        req_valid = 4'h0;
        tick();

        // single op on requester 0
        set_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1 chk_eq("single_ready", 32'(req_ready), 32'h1);
        tick();
        chk_rsp("single", 2'd0, 16'h2233, 1'b0);
        req_valid = 4'h0;
        tick();
        chk_eq("drain_valid", 32'(rsp_valid), 32'h0);

        // round-robin from ptr=1
        for (int i = 0; i < 4; i++) set_op(i, 16'(i) << 8, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 chk_eq("rr_ready", 32'(req_ready), 32'(1 << rr_exp[k]));
            tick();
            chk_rsp("rr", 2'(rr_exp[k]), (16'(rr_exp[k]) << 8) + 16'h1, 1'b0);
        end
        req_valid = 4'h0;
        tick();

        // chaining on requester 2, then chain=1 on requester 3 with cy[3]=0
        set_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1 chk_eq("chain_ready", 32'(req_ready), 32'h4);
        tick();
        chk_rsp("chain0", 2'd2, 16'h0000, 1'b1);
        set_op(2, 16'h0000, 16'h0000, 1'b1, 1'b0);
        tick();
        chk_rsp("chain1", 2'd2, 16'h0001, 1'b0);
        set_op(3, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        req_valid = 4'b1000;
        tick();
        chk_rsp("chain3", 2'd3, 16'hFFFF, 1'b0);

        // lock sequence on requester 1 (ptr=0)
        for (int i = 0; i < 4; i++) set_op(i, 16'h0000, 16'h0000, 1'b0, 1'b0);
        set_op(1, 16'h8000, 16'h8000, 1'b1, 1'b1);
        req_valid = 4'b0010;
        #1 chk_eq("lock_ready0", 32'(req_ready), 32'h2);
        tick();
        chk_rsp("lock0", 2'd1, 16'h0000, 1'b1);
        req_valid = 4'hF;
        #1 chk_eq("lock_ready1", 32'(req_ready), 32'h2);
        tick();
        chk_rsp("lock1", 2'd1, 16'h0001, 1'b1);
        set_op(1, 16'h8000, 16'h8000, 1'b1, 1'b0);
        #1 chk_eq("lock_ready2", 32'(req_ready), 32'h2);
        tick();
        chk_rsp("lock2", 2'd1, 16'h0001, 1'b1);
        set_op(2, 16'h0005, 16'h0007, 1'b0, 1'b0);
        set_op(3, 16'h0010, 16'h0020, 1'b0, 1'b0);
        #1 chk_eq("unlock_ready", 32'(req_ready), 32'h4);
        tick();
        chk_rsp("unlock", 2'd2, 16'h000C, 1'b0);

        // back-pressure with a pending response
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk_eq("bp_ready", 32'(req_ready), 32'h0);
            tick();
            chk_rsp("bp_hold", 2'd2, 16'h000C, 1'b0);
        end
        rsp_ready = 1'b1;
        #1 chk_eq("bp_release_ready", 32'(req_ready), 32'h8);
        tick();
        chk_rsp("bp_overwrite", 2'd3, 16'h0030, 1'b0);
        req_valid = 4'h0;
        tick();
        chk_eq("bp_drain_valid", 32'(rsp_valid), 32'h0);
        chk_eq("bp_drain_sum",   32'(rsp_sum),   32'h30);

        // reset while locked with a pending response
        set_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        req_valid = 4'b0001;
        tick();
        chk_rsp("pre_rst0", 2'd0, 16'h0000, 1'b1);
        set_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        req_valid = 4'b0010;
        #1 chk_eq("pre_rst_ready", 32'(req_ready), 32'h2);
        tick();
        chk_rsp("pre_rst1", 2'd1, 16'h0000, 1'b1);
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk_eq("mid_rst_ready", 32'(req_ready), 32'h0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 16'h0000, 16'h0000, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        #1 chk_eq("post_rst_ready0", 32'(req_ready), 32'h1);
        tick();
        chk_rsp("post_rst0", 2'd0, 16'h0000, 1'b0);
        #1 chk_eq("post_rst_ready1", 32'(req_ready), 32'h2);
        tick();
        chk_rsp("post_rst1", 2'd1, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
